// File: rtl/output_result_drain.sv
// ---------------------------------------------------------------------------
// output_result_drain
//
// Collects completed bottom-kernel-row sums from the convolution datapath,
// discards the beats that fall in the kernel's left/top halo, tags the
// remaining results with their output (row, col) position and queues them
// in a small FIFO for a valid/ready downstream consumer.
//
// Parameters
//   DEPTH       output FIFO entries (power of two, >= 2)
//   INPUT_ROWS  input rows per frame (>= 2)
//
// Legacy geometry macros (defaults supplied below if not set by the build):
//   `OUT_BIN_LEN, `INPUT_WIDTH, `INPUT_WIDTH_LOG, `KERNEL_WIDTH, `KERNEL_HEIGHT
//
// Optional feature macro:
//   OUT_DRAIN_RELU_EN  when defined, in_val is two's complement and negative
//                      values are queued as zero; otherwise queued unmodified.
//
// Ports
//   clock        sole clock, all state on posedge
//   reset        synchronous, active-high; clears counters, FIFO, flags
//   enable       in_val / width_index valid this cycle
//   in_val       completed bottom-kernel-row sum for the current column
//   width_index  current input column
//   out_valid    FIFO head holds a result
//   out_ready    downstream accepts the head this cycle
//   out_val      head result value (0 while the FIFO is empty)
//   out_col      output column of head
//   out_row      output row of head
//   frame_done   one-cycle pulse after the last column of the last row
//   overflow     sticky; a result was dropped because the FIFO was full
// ---------------------------------------------------------------------------

`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 3
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif

module output_result_drain #(
  parameter int DEPTH      = 8,
  parameter int INPUT_ROWS = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [`OUT_BIN_LEN-1:0]         in_val,
  input  logic [`INPUT_WIDTH_LOG-1:0]     width_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [`OUT_BIN_LEN-1:0]         out_val,
  output logic [`INPUT_WIDTH_LOG-1:0]     out_col,
  output logic [$clog2(INPUT_ROWS)-1:0]   out_row,
  output logic                            frame_done,
  output logic                            overflow
);

  localparam int VAL_W  = `OUT_BIN_LEN;
  localparam int IDX_W  = `INPUT_WIDTH_LOG;
  localparam int ROW_W  = $clog2(INPUT_ROWS);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  // One extra bit so an index of exactly the column limit is still
  // representable and the range test stays meaningful at any geometry.
  localparam int IDX_EXT_W = IDX_W + 1;

  localparam logic [IDX_EXT_W-1:0] LAST_COL_EXT  = IDX_EXT_W'(`INPUT_WIDTH - 1);
  localparam logic [IDX_EXT_W-1:0] FIRST_OUT_EXT = IDX_EXT_W'(`KERNEL_WIDTH - 1);
  localparam logic [IDX_W-1:0]     COL_OFFSET    = IDX_W'(`KERNEL_WIDTH - 1);
  localparam logic [ROW_W-1:0]     LAST_ROW      = ROW_W'(INPUT_ROWS - 1);
  localparam logic [ROW_W-1:0]     ROW_OFFSET    = ROW_W'(`KERNEL_HEIGHT - 1);
  localparam logic [ROW_W-1:0]     ROW_ONE       = ROW_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE       = PTR_W'(1);

  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic [IDX_W-1:0] col;
    logic [ROW_W-1:0] row;
  } entry_t;

  // ---------------------------------------------------------------------
  // Input beat classification
  // ---------------------------------------------------------------------
  logic [IDX_EXT_W-1:0] col_ext;
  logic                 col_beat;
  logic                 row_end;
  logic                 in_halo_free;
  logic                 want_push;
  logic [ROW_W-1:0]     in_row;
  logic [VAL_W-1:0]     push_val;
  entry_t               push_entry;

  always_comb begin
    col_ext      = {1'b0, width_index};
    col_beat     = enable && (col_ext <= LAST_COL_EXT);
    row_end      = col_beat && (col_ext == LAST_COL_EXT);
    in_halo_free = (col_ext >= FIRST_OUT_EXT) && (in_row >= ROW_OFFSET);
    want_push    = col_beat && in_halo_free;
  end

`ifdef OUT_DRAIN_RELU_EN
  always_comb begin
    push_val = in_val[VAL_W-1] ? '0 : in_val;
  end
`else
  always_comb begin
    push_val = in_val;
  end
`endif

  always_comb begin
    push_entry.val = push_val;
    push_entry.col = width_index - COL_OFFSET;
    push_entry.row = in_row - ROW_OFFSET;
  end

  // ---------------------------------------------------------------------
  // Row counter and end-of-frame pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      in_row     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= row_end && (in_row == LAST_ROW);
      if (row_end) begin
        in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO: pointers carry a wrap bit so full and empty are distinct when
  // the address bits match.
  // ---------------------------------------------------------------------
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             do_push;
  logic             drop;
  entry_t           head;

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    pop        = !fifo_empty && out_ready;
    // A full FIFO still takes the push when the head leaves the same cycle;
    // the write lands in the slot being vacated.
    do_push    = want_push && (!fifo_full || pop);
    drop       = want_push && fifo_full && !pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is visible until a push has written it.
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------
  // Head presentation; fields forced to zero while empty so that stale
  // storage never reaches the outputs after reset.
  // ---------------------------------------------------------------------
  always_comb begin
    head      = mem[rd_ptr[ADDR_W-1:0]];
    out_valid = !fifo_empty;
    out_val   = out_valid ? head.val : '0;
    out_col   = out_valid ? head.col : '0;
    out_row   = out_valid ? head.row : '0;
  end

endmodule

// File: tb/tb_output_result_drain.sv
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 3
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif

module tb_output_result_drain;

  localparam int W     = `OUT_BIN_LEN;
  localparam int DEPTH = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int KW    = 3;
  localparam int KH    = 3;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         enable;
  logic [W-1:0]                 in_val;
  logic [`INPUT_WIDTH_LOG-1:0]  width_index;
  logic                         out_valid;
  logic                         out_ready;
  logic [W-1:0]                 out_val;
  logic [`INPUT_WIDTH_LOG-1:0]  out_col;
  logic [1:0]                   out_row;
  logic                         frame_done;
  logic                         overflow;

  int checks = 0;
  int errors = 0;

  output_result_drain #(.DEPTH(DEPTH), .INPUT_ROWS(ROWS)) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_val(in_val),
    .width_index(width_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_col(out_col), .out_row(out_row),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of tagged results plus frame position.
  typedef struct {
    logic [W-1:0] val;
    int           col;
    int           row;
  } ent_t;

  ent_t m_q[$];
  int   m_row = 0;
  bit   m_ovf = 0;
  bit   m_fd  = 0;

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef OUT_DRAIN_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Advance one clock: model reacts to the inputs present before the edge,
  // outputs are then sampled 1 time unit after the edge.
  task automatic step();
    bit   pop;
    bit   beat;
    int   idx;
    ent_t e;
    idx  = int'(width_index);
    pop  = (m_q.size() != 0) && out_ready;
    beat = enable && (idx <= COLS - 1);
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      m_row = 0;
      m_ovf = 0;
      m_fd  = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      m_fd = 0;
      if (beat) begin
        if (idx >= KW - 1 && m_row >= KH - 1) begin
          e.val = relu(in_val);
          e.col = idx - (KW - 1);
          e.row = m_row - (KH - 1);
          if (m_q.size() < DEPTH) m_q.push_back(e);
          else m_ovf = 1;
        end
        if (idx == COLS - 1) begin
          m_fd  = (m_row == ROWS - 1);
          m_row = (m_row + 1) % ROWS;
        end
      end
    end
    #1;
  endtask

  task automatic cyc(input bit en, input int idx, input logic [W-1:0] val, input bit rdy);
    int t;
    t           = idx;
    enable      = en;
    width_index = t[`INPUT_WIDTH_LOG-1:0];
    in_val      = val;
    out_ready   = rdy;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic feed_rows(input int n, input bit rdy);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < COLS; i++)
        cyc(1'b1, i, W'($urandom), rdy);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; width_index = '0; in_val = '1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_val !== '0 || out_col !== '0 || out_row !== '0 ||
          overflow !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc%0d got v=%b val=%h col=%0d row=%0d ovf=%b fd=%b exp all 0",
                 k, out_valid, out_val, out_col, out_row, overflow, frame_done);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < COLS; i++) begin
        cyc(1'b1, i, W'($urandom), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_halo_rows r%0d i%0d out_valid got %b exp 0", r, i, out_valid);
        end
      end
    for (int i = 0; i < COLS; i++) begin
      cyc(1'b1, i, W'(i * 10), 1'b1);
      checks++;
      if (i < 2) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_left_halo i%0d out_valid got %b exp 0", i, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_val !== W'(i * 10) ||
                   int'(out_col) != i - 2 || out_row !== 2'd0) begin
        errors++;
        $display("FAIL basic_output i%0d got v=%b val=%0d col=%0d row=%0d exp v=1 val=%0d col=%0d row=0",
                 i, out_valid, out_val, out_col, out_row, i * 10, i - 2);
      end
    end
    cyc(1'b0, 0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drained out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    feed_rows(2, 1'b1);
    for (int i = 0; i < COLS; i++) begin
      cyc(1'b1, i, W'(i * 10), 1'b0);
      checks++;
      if (overflow !== (i >= 6)) begin
        errors++;
        $display("FAIL ovf_flag i%0d got %b exp %b", i, overflow, i >= 6);
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_val !== W'(20) || out_col !== '0) begin
          errors++;
          $display("FAIL ovf_hold i%0d got v=%b val=%0d col=%0d exp v=1 val=20 col=0",
                   i, out_valid, out_val, out_col);
        end
      end
    end
    n = 0;
    while (out_valid === 1'b1 && n < 8) begin
      checks++;
      if (int'(out_col) != n || out_val !== W'((n + 2) * 10)) begin
        errors++;
        $display("FAIL ovf_drain n%0d got col=%0d val=%0d exp col=%0d val=%0d",
                 n, out_col, out_val, n, (n + 2) * 10);
      end
      n++;
      cyc(1'b0, 0, '0, 1'b1);
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL ovf_held_count got %0d exp %0d", n, DEPTH);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    do_reset();
    feed_rows(2, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, i, W'(i * 10), 1'b0);
    cyc(1'b1, 6, W'(60), 1'b1);
    checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b1 || out_val !== W'(30) || out_col !== 3'd1) begin
      errors++;
      $display("FAIL full_pushpop got ovf=%b v=%b val=%0d col=%0d exp ovf=0 v=1 val=30 col=1",
               overflow, out_valid, out_val, out_col);
    end
    n = 0;
    while (out_valid === 1'b1 && n < 8) begin
      checks++;
      if (int'(out_col) != n + 1 || out_val !== W'((n + 3) * 10)) begin
        errors++;
        $display("FAIL full_drain n%0d got col=%0d val=%0d exp col=%0d val=%0d",
                 n, out_col, out_val, n + 1, (n + 3) * 10);
      end
      n++;
      cyc(1'b0, 0, '0, 1'b1);
    end
    checks++;
    if (n != DEPTH || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_occupancy got n=%0d ovf=%b exp n=%0d ovf=0", n, overflow, DEPTH);
    end
  endtask

  task automatic test_frame();
    int pulses;
    do_reset();
    pulses = 0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < COLS; i++) begin
        cyc(1'b1, i, W'($urandom), 1'b1);
        pulses += int'(frame_done);
        checks++;
        if (frame_done !== (r == ROWS - 1 && i == COLS - 1)) begin
          errors++;
          $display("FAIL frame_done_r%0d_i%0d got %b exp %b", r, i, frame_done,
                   r == ROWS - 1 && i == COLS - 1);
        end
        checks++;
        if (out_valid !== (m_q.size() != 0) ||
            (m_q.size() != 0 && (out_val !== m_q[0].val || int'(out_row) != m_q[0].row))) begin
          errors++;
          $display("FAIL frame_head r%0d i%0d got v=%b val=%h row=%0d", r, i, out_valid, out_val, out_row);
        end
      end
    for (int i = 0; i < COLS; i++) begin
      cyc(1'b1, i, W'($urandom), 1'b1);
      pulses += int'(frame_done);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL frame_next_row0 i%0d out_valid got %b exp 0", i, out_valid);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL frame_pulse_count got %0d exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed_rows(2, 1'b1);
    for (int i = 2; i < 5; i++) cyc(1'b1, i, W'(100 + i), 1'b0);
    checks++;
    if (out_valid !== 1'b1 || m_q.size() != 3) begin
      errors++;
      $display("FAIL rstmid_setup got v=%b exp 1", out_valid);
    end
    reset = 1'b1;
    cyc(1'b1, 7, W'(1), 1'b1);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_val !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%b ovf=%b val=%h fd=%b exp 0 0 0 0",
               out_valid, overflow, out_val, frame_done);
    end
    for (int i = 5; i < COLS; i++) begin
      cyc(1'b1, i, W'(1), 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_row0 i%0d out_valid got %b exp 0", i, out_valid);
      end
    end
    feed_rows(1, 1'b1);
    cyc(1'b1, 2, W'(77), 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_val !== W'(77) || out_col !== '0 || out_row !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_first_push got v=%b val=%0d col=%0d row=%0d exp 1 77 0 0",
               out_valid, out_val, out_col, out_row);
    end
  endtask

  task automatic test_relu();
    logic [W-1:0] ones;
    logic [W-1:0] pos;
    ones = '1;
    pos  = W'(16'h1234);
    do_reset();
    feed_rows(2, 1'b1);
    cyc(1'b1, 2, ones, 1'b1);
    checks++;
`ifdef OUT_DRAIN_RELU_EN
    if (out_valid !== 1'b1 || out_val !== '0) begin
      errors++;
      $display("FAIL relu_neg got v=%b val=%h exp v=1 val=0", out_valid, out_val);
    end
`else
    if (out_valid !== 1'b1 || out_val !== ones) begin
      errors++;
      $display("FAIL relu_passthru got v=%b val=%h exp v=1 val=%h", out_valid, out_val, ones);
    end
`endif
    cyc(1'b1, 3, pos, 1'b1);
    checks++;
    if (out_val !== pos) begin
      errors++;
      $display("FAIL relu_pos got %h exp %h", out_val, pos);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, COLS - 1),
          W'($urandom), ($urandom_range(0, 2) != 0));
      checks++;
      if (out_valid !== (m_q.size() != 0) || overflow !== m_ovf || frame_done !== m_fd) begin
        errors++;
        $display("FAIL rand_flags k%0d got v=%b ovf=%b fd=%b exp v=%b ovf=%b fd=%b",
                 k, out_valid, overflow, frame_done, m_q.size() != 0, m_ovf, m_fd);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (out_val !== m_q[0].val || int'(out_col) != m_q[0].col || int'(out_row) != m_q[0].row) begin
          errors++;
          $display("FAIL rand_head k%0d got val=%h col=%0d row=%0d exp val=%h col=%0d row=%0d",
                   k, out_val, out_col, out_row, m_q[0].val, m_q[0].col, m_q[0].row);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_val = '0; width_index = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_reset_mid();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_result_drain.md
OUTPUT_RESULT_DRAIN -- requirements
Module: output_result_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter INPUT_ROWS, default 16, meaning input rows per frame.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  in_val/width_index valid this cycle (same strobe as partial-sum store).
REQ-006 SHALL have port in_val  input  `OUT_BIN_LEN  completed bottom-kernel-row sum for current column.
REQ-007 SHALL have port width_index  input  `INPUT_WIDTH_LOG  current input column.
REQ-008 SHALL have port out_valid  output  1  FIFO head holds a result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts head this cycle.
REQ-010 SHALL have port out_val  output  `OUT_BIN_LEN  head result value.
REQ-011 SHALL have port out_col  output  `INPUT_WIDTH_LOG  output column of head.
REQ-012 SHALL have port out_row  output  $clog2(INPUT_ROWS)  output row of head.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after last column of last row accepted.
REQ-014 SHALL have port overflow  output  1  sticky, a result was dropped on full FIFO.

Function
REQ-015 SHALL treat a cycle as a column beat when enable=1 and width_index <= `INPUT_WIDTH-1.
REQ-016 SHALL keep input row counter in_row; increment on column beat with width_index=`INPUT_WIDTH-1; wrap INPUT_ROWS-1 -> 0.
REQ-017 SHALL push when column beat, width_index >= `KERNEL_WIDTH-1 and in_row >= `KERNEL_HEIGHT-1; all other beats silently discarded.
REQ-018 SHALL tag pushed entry with col = width_index-(`KERNEL_WIDTH-1), row = in_row-(`KERNEL_HEIGHT-1).
REQ-019 SHALL pop head when out_valid=1 and out_ready=1; out_valid = FIFO non-empty.
REQ-020 SHALL present a push into an empty FIFO on out_valid/out_val/out_col/out_row the next cycle (1-cycle latency).
REQ-021 SHALL accept push on full FIFO only if a pop occurs same cycle; otherwise drop entry and set overflow=1.
REQ-022 SHALL allow simultaneous push and pop at any occupancy; occupancy unchanged.
REQ-023 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH with distinct full/empty detection.
REQ-025 SHALL pulse frame_done for exactly one cycle following column beat with width_index=`INPUT_WIDTH-1 and in_row=INPUT_ROWS-1, independent of whether that entry was dropped.
REQ-026 SHALL ignore width_index > `INPUT_WIDTH-1 (no push, no counter change).

Reset
REQ-027 SHALL on reset=1 at posedge clear in_row, FIFO pointers and occupancy, overflow, frame_done.
REQ-028 SHALL drive out_valid=0, out_val=0, out_col=0, out_row=0 while reset and after until first push.
REQ-029 SHALL discard in-flight FIFO contents when reset asserts mid-frame; reset has priority over enable and out_ready.

Configuration
REQ-030 SHALL, with OUT_DRAIN_RELU_EN defined, treat in_val as two's complement and push 0 when its MSB=1.
REQ-031 SHALL, without OUT_DRAIN_RELU_EN, push in_val unmodified.

Verification (KERNEL_WIDTH=3, KERNEL_HEIGHT=3, INPUT_WIDTH=8, DEPTH=4, INPUT_ROWS=4)
REQ-032 SHALL cover: 2 rows of beats, out_ready=1 -> no out_valid; row 2 beats idx 0..7 with in_val=idx*10 -> 6 outputs col 0..5, row 0, vals 20..70, each 1 cycle after push.
REQ-033 SHALL cover: out_ready=0, row 2 pushes 6 -> 4 held (cols 0..3), overflow=1 after col 4, out_val stable at 20.
REQ-034 SHALL cover: FIFO full with out_ready=1 and push same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-035 SHALL cover: full 4-row frame -> frame_done single pulse after row 3 idx 7; in_row back to 0; next frame row 0 produces no output.
REQ-036 SHALL cover: reset asserted with 3 entries queued mid-row -> next cycle out_valid=0, overflow=0, next push tagged from in_row=0 rules.
REQ-037 SHALL cover: OUT_DRAIN_RELU_EN defined, in_val=all ones -> out_val=0; undefined -> out_val=all ones.
